if_fetch: RTL and testbench

//  Instruction-fetch stage of the 16-bit pipeline. Owns the PC and issues word

---
 rtl/if_fetch_pkg.sv | 25 ++
 rtl/if_skid_buf.sv | 38 +++
 rtl/if_fetch.sv | 131 +++++++++++++
 tb/tb_if_fetch.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
// Holds the NOP encoding, the fetch FSM state encodings, the skid entry layout and the PC adder.
package if_fetch_pkg;

  localparam int PC_W = 16;

  localparam logic [PC_W-1:0] NOP_INS = 16'h0800;

  localparam logic [1:0] IF_IDLE = 2'd0;
  localparam logic [1:0] IF_REQ  = 2'd1;
  localparam logic [1:0] IF_DATA = 2'd2;
  localparam logic [1:0] IF_HOLD = 2'd3;

  typedef struct packed {
    logic [PC_W-1:0] ins;
    logic [PC_W-1:0] pc;
  } fetch_entry_t;

  // Plain modulo-2^16 add; overflow wraps silently.
  function automatic logic [PC_W-1:0] pc_add(input logic [PC_W-1:0] a,
                                             input logic [PC_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for a fetch response that arrives while the stage is paused.
// Clear has priority over Load, so a redirect in the same cycle discards the response.
module if_skid_buf
  import if_fetch_pkg::*;
(
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Load,
  input  logic            Clear,
  input  logic [PC_W-1:0] LoadIns,
  input  logic [PC_W-1:0] LoadPc,
  output logic            Valid,
  output logic [PC_W-1:0] Ins,
  output logic [PC_W-1:0] Pc
);

  fetch_entry_t entry;
  logic         valid_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid_q   <= 1'b0;
      entry.ins <= NOP_INS;
      entry.pc  <= '0;
    end else if (Clear) begin
      valid_q   <= 1'b0;
    end else if (Load) begin
      valid_q   <= 1'b1;
      entry.ins <= LoadIns;
      entry.pc  <= LoadPc;
    end
  end

  assign Valid = valid_q;
  assign Ins   = entry.ins;
  assign Pc    = entry.pc;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches one word per accepted request,
// and presents instruction + next-PC to IF/ID, honouring Pause and branch redirects.
//
// Memory handshake: a request transfers on a cycle where InsReq=1 and InsGrant=1;
// InsReq may depend on Pause/BranchTaken this cycle and is never raised during reset,
// redirect or Pause. InsRdata for a transferred request is valid exactly one cycle later.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'd1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Pause,
  input  logic        BranchTaken,
  input  logic [15:0] BranchTarget,
  output logic        InsReq,
  output logic [15:0] InsAddr,
  input  logic        InsGrant,
  input  logic [15:0] InsRdata,
  output logic [15:0] PcAddr4,
  output logic [15:0] InsOut,
  output logic        InsValid,
  output logic        IfIdRst,
  output logic [1:0]  DbgState
);

  logic [1:0]  state;
  logic [15:0] pc;
  logic [15:0] resp_pc;
  logic [15:0] ins_out_q;
  logic [15:0] pc_addr4_q;
  logic        ins_valid_q;
  logic        if_id_rst_q;

  logic        accept;
  logic        skid_load;
  logic        skid_clear;
  logic        skid_valid;
  logic [15:0] skid_ins;
  logic [15:0] skid_pc;

  // Requests stop during Pause so at most one response can be in flight into the skid.
  assign InsReq = !Rst && !BranchTaken && !Pause &&
                  ((state == IF_REQ) || (state == IF_DATA));
  assign InsAddr = pc;
  assign accept  = InsReq && InsGrant;

  assign skid_load  = !BranchTaken && (state == IF_DATA) && Pause;
  assign skid_clear = BranchTaken || ((state == IF_HOLD) && !Pause);

  if_skid_buf u_skid (
    .Clk     (Clk),
    .Rst     (Rst),
    .Load    (skid_load),
    .Clear   (skid_clear),
    .LoadIns (InsRdata),
    .LoadPc  (resp_pc),
    .Valid   (skid_valid),
    .Ins     (skid_ins),
    .Pc      (skid_pc)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IF_IDLE;
      pc          <= RESET_PC;
      resp_pc     <= '0;
      ins_out_q   <= NOP_INS;
      pc_addr4_q  <= '0;
      ins_valid_q <= 1'b0;
      if_id_rst_q <= 1'b0;
    end else begin
      if_id_rst_q <= BranchTaken;
      if (BranchTaken) begin
        // Redirect wins over Pause; the PC moves even while downstream is stalled.
        pc          <= BranchTarget;
        ins_out_q   <= NOP_INS;
        ins_valid_q <= 1'b0;
        state       <= IF_REQ;
      end else begin
        case (state)
          IF_IDLE: state <= IF_REQ;
          IF_REQ: begin
            if (!Pause) begin
              ins_out_q   <= NOP_INS;
              ins_valid_q <= 1'b0;
              if (accept) begin
                resp_pc <= pc;
                pc      <= pc_add(pc, PC_INC);
                state   <= IF_DATA;
              end
            end
          end
          IF_DATA: begin
            if (Pause) begin
              state <= IF_HOLD;
            end else begin
              ins_out_q   <= InsRdata;
              pc_addr4_q  <= pc_add(resp_pc, PC_INC);
              ins_valid_q <= 1'b1;
              if (accept) begin
                resp_pc <= pc;
                pc      <= pc_add(pc, PC_INC);
              end else begin
                state <= IF_REQ;
              end
            end
          end
          IF_HOLD: begin
            if (!Pause) begin
              ins_out_q   <= skid_ins;
              pc_addr4_q  <= pc_add(skid_pc, PC_INC);
              ins_valid_q <= skid_valid;
              state       <= IF_REQ;
            end
          end
          default: state <= IF_IDLE;
        endcase
      end
    end
  end

  assign InsOut   = ins_out_q;
  assign PcAddr4  = pc_addr4_q;
  assign InsValid = ins_valid_q;
  assign IfIdRst  = if_id_rst_q;
  assign DbgState = state;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a one-cycle-latency memory model answers granted requests,
// and each step checks registered outputs after the edge and InsReq after inputs settle.
module tb_if_fetch;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Pause;
  logic        BranchTaken;
  logic [15:0] BranchTarget;
  logic        InsReq;
  logic [15:0] InsAddr;
  logic        InsGrant;
  logic [15:0] InsRdata;
  logic [15:0] PcAddr4;
  logic [15:0] InsOut;
  logic        InsValid;
  logic        IfIdRst;
  logic [1:0]  DbgState;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [15:0] NOP = 16'h0800;

  if_fetch dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Pause        (Pause),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .InsReq       (InsReq),
    .InsAddr      (InsAddr),
    .InsGrant     (InsGrant),
    .InsRdata     (InsRdata),
    .PcAddr4      (PcAddr4),
    .InsOut       (InsOut),
    .InsValid     (InsValid),
    .IfIdRst      (IfIdRst),
    .DbgState     (DbgState)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'h0010) ? 16'h4A05 : (a ^ 16'hC35A);
  endfunction

  initial InsRdata = 16'h0000;
  always @(posedge Clk) begin
    if (InsReq && InsGrant) InsRdata <= mem_word(InsAddr);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] ins,
                         input logic [15:0] pa4);
    chk({tag, "_valid"}, {15'b0, InsValid}, {15'b0, v});
    chk({tag, "_ins"}, InsOut, ins);
    chk({tag, "_pa4"}, PcAddr4, pa4);
  endtask

  initial begin
    Rst = 1'b1; Pause = 1'b0; BranchTaken = 1'b0; BranchTarget = 16'h0000; InsGrant = 1'b1;
    // reset, then linear fetch
    tick(); tick();
    chk("rst_req", {15'b0, InsReq}, 16'h0);
    chk("rst_addr", InsAddr, 16'h0000);
    chk("rst_iirst", {15'b0, IfIdRst}, 16'h0);
    chk_out("rst", 1'b0, NOP, 16'h0000);
    Rst = 1'b0; #1;
    chk("c0_req_idle", {15'b0, InsReq}, 16'h0);
    tick();
    chk("c1_req", {15'b0, InsReq}, 16'h1);
    chk("c1_addr", InsAddr, 16'h0000);
    tick();
    chk("c2_addr", InsAddr, 16'h0001);
    chk("c2_valid", {15'b0, InsValid}, 16'h0);
    for (int k = 3; k <= 6; k++) begin
      tick();
      chk("lin_addr", InsAddr, 16'(k - 1));
      chk_out("lin", 1'b1, mem_word(16'(k - 3)), 16'(k - 2));
    end
    // pause for three cycles while in DATA
    Pause = 1'b1; #1;
    chk("p6_req", {15'b0, InsReq}, 16'h0);
    tick();
    chk("p7_req", {15'b0, InsReq}, 16'h0);
    chk("p7_state", {14'b0, DbgState}, 16'h3);
    chk_out("p7", 1'b1, mem_word(16'h0003), 16'h0004);
    tick();
    chk_out("p8", 1'b1, mem_word(16'h0003), 16'h0004);
    chk("p8_addr", InsAddr, 16'h0005);
    tick();
    Pause = 1'b0; #1;
    chk("p9_req", {15'b0, InsReq}, 16'h0);
    chk_out("p9", 1'b1, mem_word(16'h0003), 16'h0004);
    tick();
    chk_out("p10_skid", 1'b1, mem_word(16'h0004), 16'h0005);
    chk("p10_addr", InsAddr, 16'h0005);
    chk("p10_req", {15'b0, InsReq}, 16'h1);
    tick();
    chk_out("p11", 1'b0, NOP, 16'h0005);
    chk("p11_addr", InsAddr, 16'h0006);
    tick();
    chk_out("p12", 1'b1, mem_word(16'h0005), 16'h0006);
    // grant withheld for four cycles
    InsGrant = 1'b0;
    tick();
    chk_out("g13", 1'b1, mem_word(16'h0006), 16'h0007);
    chk("g13_req", {15'b0, InsReq}, 16'h1);
    chk("g13_addr", InsAddr, 16'h0007);
    tick();
    chk_out("g14", 1'b0, NOP, 16'h0007);
    chk("g14_addr", InsAddr, 16'h0007);
    tick();
    chk("g15_req", {15'b0, InsReq}, 16'h1);
    chk("g15_addr", InsAddr, 16'h0007);
    tick();
    chk_out("g16", 1'b0, NOP, 16'h0007);
    InsGrant = 1'b1;
    tick();
    chk("g17_addr", InsAddr, 16'h0008);
    tick();
    chk_out("g18", 1'b1, mem_word(16'h0007), 16'h0008);
    // branch to 0x0010
    BranchTaken = 1'b1; BranchTarget = 16'h0010; #1;
    chk("b18_req", {15'b0, InsReq}, 16'h0);
    tick();
    BranchTaken = 1'b0; #1;
    chk("b19_iirst", {15'b0, IfIdRst}, 16'h1);
    chk("b19_addr", InsAddr, 16'h0010);
    chk("b19_valid", {15'b0, InsValid}, 16'h0);
    chk("b19_ins", InsOut, NOP);
    tick();
    chk("b20_iirst", {15'b0, IfIdRst}, 16'h0);
    chk("b20_valid", {15'b0, InsValid}, 16'h0);
    tick();
    chk_out("b21", 1'b1, 16'h4A05, 16'h0011);
    // branch and pause together in DATA
    BranchTaken = 1'b1; BranchTarget = 16'h0040; Pause = 1'b1;
    tick();
    BranchTaken = 1'b0; #1;
    chk("bp22_iirst", {15'b0, IfIdRst}, 16'h1);
    chk("bp22_req", {15'b0, InsReq}, 16'h0);
    chk("bp22_addr", InsAddr, 16'h0040);
    chk("bp22_valid", {15'b0, InsValid}, 16'h0);
    tick();
    chk("bp23_req", {15'b0, InsReq}, 16'h0);
    chk("bp23_state", {14'b0, DbgState}, 16'h1);
    Pause = 1'b0; #1;
    chk("bp23_req_rel", {15'b0, InsReq}, 16'h1);
    chk("bp23_addr", InsAddr, 16'h0040);
    tick();
    chk("bp24_valid", {15'b0, InsValid}, 16'h0);
    tick();
    chk_out("bp25", 1'b1, mem_word(16'h0040), 16'h0041);
    // PC wrap at 0xFFFF
    BranchTaken = 1'b1; BranchTarget = 16'hFFFF;
    tick();
    BranchTaken = 1'b0;
    chk("w26_addr", InsAddr, 16'hFFFF);
    tick();
    chk("w27_addr", InsAddr, 16'h0000);
    tick();
    chk_out("w28", 1'b1, mem_word(16'hFFFF), 16'h0000);
    chk("w28_addr", InsAddr, 16'h0001);
    // reset in the middle of DATA
    Rst = 1'b1; #1;
    chk("r28_req", {15'b0, InsReq}, 16'h0);
    tick();
    Rst = 1'b0; #1;
    chk_out("r29", 1'b0, NOP, 16'h0000);
    chk("r29_addr", InsAddr, 16'h0000);
    chk("r29_state", {14'b0, DbgState}, 16'h0);
    tick();
    tick();
    chk("r31_addr", InsAddr, 16'h0001);
    chk("r31_valid", {15'b0, InsValid}, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    n_fail++;
    $display("FAIL timeout: observed no completion expected finish before 20000");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
